// File: rtl/vend_pkg.sv
// vend_pkg: shared cash codes, FSM state encoding and note values for the vending sequencer
package vend_pkg;
    typedef enum logic [1:0] {
        CASH_NONE = 2'b00,
        CASH_10   = 2'b01,
        CASH_20   = 2'b10,
        CASH_BAD  = 2'b11
    } cash_t;
    typedef enum logic [1:0] {
        ST_IDLE,
        ST_COLLECT,
        ST_VEND,
        ST_PAYOUT
    } state_t;
    localparam logic [6:0] NOTE_10 = 7'd10;
    localparam logic [6:0] NOTE_20 = 7'd20;
    function automatic logic [6:0] note_value(input logic [1:0] code);
        return code == CASH_10 ? NOTE_10 : code == CASH_20 ? NOTE_20 : 7'd0;
    endfunction
endpackage

// File: rtl/vend_timer.sv
// vend_timer: idle-cycle counter; expired is high on the TIMEOUT_CYC-th consecutive enabled cycle
// Ports: clk, rst (async active-low), clear (restart count), enable (count this cycle), expired
module vend_timer #(
    parameter int TIMEOUT_CYC = 1000
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic expired
);
    localparam int W = $clog2(TIMEOUT_CYC + 1);
    localparam logic [W-1:0] LAST = W'(TIMEOUT_CYC - 1);
    logic [W-1:0] r_cnt;
    always_ff @(posedge clk or negedge rst)
        if (!rst)
            r_cnt <= '0;
        else if (clear)
            r_cnt <= '0;
        else if (enable)
            r_cnt <= r_cnt + 1'b1;
    assign expired = enable && r_cnt == LAST;
endmodule

// File: rtl/vend_sequencer.sv
// vend_sequencer: note-collecting vending FSM with dispense handshake and Rs10 coin change payout
// Ports: clk, rst (async active-low), cash (note code), cancel, disp_done, hopper_ready ->
//        dispense (held until disp_done), coin_out / reject (one-cycle pulses), busy, credit (rupees)
module vend_sequencer import vend_pkg::*; #(
    parameter int PRICE       = 30,
    parameter int MAX_CREDIT  = 90,
    parameter int TIMEOUT_CYC = 1000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] cash,
    input  logic       cancel,
    input  logic       disp_done,
    input  logic       hopper_ready,
    output logic       dispense,
    output logic       coin_out,
    output logic       reject,
    output logic       busy,
    output logic [6:0] credit
);
    localparam logic [6:0] PRICE_C = 7'(PRICE);
    localparam logic [7:0] MAX_C   = 8'(MAX_CREDIT);
    state_t     r_state, w_state_nxt;
    logic [6:0] r_credit, w_credit_nxt;
    logic       r_coin_out, r_reject, w_coin_nxt, w_reject_nxt;
    logic [7:0] w_sum;
    logic       w_accept, w_timeout, w_tmr_clear, w_tmr_en;
    assign w_sum = {1'b0, r_credit} + {1'b0, note_value(cash)};
    // Notes are taken only while collecting below price; a same-cycle cancel wins over the note.
    assign w_accept = (cash == CASH_10 || cash == CASH_20) && w_sum <= MAX_C &&
                      (r_state == ST_IDLE || (r_state == ST_COLLECT && r_credit < PRICE_C && !cancel));
    assign w_tmr_clear = w_accept || r_state != ST_COLLECT;
    assign w_tmr_en    = r_state == ST_COLLECT && !w_accept;
    vend_timer #(.TIMEOUT_CYC(TIMEOUT_CYC)) u_timer (
        .clk     (clk),
        .rst     (rst),
        .clear   (w_tmr_clear),
        .enable  (w_tmr_en),
        .expired (w_timeout)
    );
    always_comb begin
        w_state_nxt  = r_state;
        w_credit_nxt = r_credit;
        w_coin_nxt   = 1'b0;
        w_reject_nxt = cash != CASH_NONE && !w_accept;
        case (r_state)
            ST_IDLE: begin
                w_state_nxt  = w_accept ? ST_COLLECT : ST_IDLE;
                w_credit_nxt = w_accept ? w_sum[6:0] : r_credit;
            end
            ST_COLLECT: begin
                w_state_nxt  = r_credit >= PRICE_C ? ST_VEND :
                               (cancel || w_timeout) ? ST_PAYOUT : ST_COLLECT;
                w_credit_nxt = w_accept ? w_sum[6:0] : r_credit;
            end
            ST_VEND: begin
                w_state_nxt  = disp_done ? ST_PAYOUT : ST_VEND;
                w_credit_nxt = disp_done ? r_credit - PRICE_C : r_credit;
            end
            default: begin
                w_state_nxt  = r_credit == 7'd0 ? ST_IDLE : ST_PAYOUT;
                w_coin_nxt   = r_credit != 7'd0 && hopper_ready;
                w_credit_nxt = w_coin_nxt ? r_credit - NOTE_10 : r_credit;
            end
        endcase
    end
    always_ff @(posedge clk or negedge rst)
        if (!rst) begin
            r_state    <= ST_IDLE;
            r_credit   <= '0;
            r_coin_out <= 1'b0;
            r_reject   <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_credit   <= w_credit_nxt;
            r_coin_out <= w_coin_nxt;
            r_reject   <= w_reject_nxt;
        end
    assign dispense = r_state == ST_VEND;
    assign busy     = r_state != ST_IDLE;
    assign coin_out = r_coin_out;
    assign reject   = r_reject;
    assign credit   = r_credit;
endmodule
